if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  rising-edge clock; only clock.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 freeze  input  1  downstream stall; output slot not consumed this cycle.
REQ-005 branch_taken  input  1  single-cycle redirect request.
REQ-006 branch_address  input  32  redirect target, valid with branch_taken.
REQ-007 imem_req  output  1  instruction-memory request, held until imem_ack.
REQ-008 imem_addr  output  32  request address, registered, stable while imem_req=1.
REQ-009 imem_ack  input  1  memory completes request; may arrive same cycle as imem_req.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 PC  output  32  address of fetched instruction plus 4, to IF/ID register.
REQ-012 Instruction  output  32  fetched instruction word, to IF/ID register.
REQ-013 valid  output  1  output slot holds a fresh instruction.

Function
REQ-014 Internal state: pc_reg (next fetch address), output slot {valid, PC, Instruction}, one-entry skid {skid_valid, skid_pc, skid_instr}.
REQ-015 consume = valid & !freeze; slot_free = !valid | consume.
REQ-016 FSM states BOOT, FETCH, WAIT_SLOT, DRAIN; state register encoded 2 bits.
REQ-017 BOOT: imem_req=0; next cycle -> FETCH with imem_addr=pc_reg.
REQ-018 FETCH: imem_req=1; on imem_ack without branch_taken: pc_reg += 4; if slot_free, slot <= {1, pc_reg+4, imem_rdata}, stay FETCH with imem_addr = pc_reg+4; else skid <= {1, pc_reg+4, imem_rdata}, -> WAIT_SLOT.
REQ-019 FETCH without imem_ack: slot cleared to valid=0 if consumed, otherwise unchanged; imem_addr unchanged.
REQ-020 WAIT_SLOT: imem_req=0; on consume, slot <= skid, skid_valid <= 0, -> FETCH with imem_addr=pc_reg.
REQ-021 DRAIN: imem_req=1 at the stale imem_addr; on imem_ack, data discarded, imem_addr <= pc_reg, -> FETCH.
REQ-022 branch_taken has priority over freeze and imem_ack: pc_reg <= branch_address, valid <= 0, skid_valid <= 0, PC/Instruction <= 0.
REQ-023 Branch transitions: FETCH w/o ack -> DRAIN; FETCH with ack -> FETCH (data discarded, imem_addr <= branch_address); WAIT_SLOT/BOOT -> FETCH at branch_address; DRAIN -> DRAIN with pc_reg updated.
REQ-024 Whenever valid=0, PC and Instruction SHALL read 32'b0 (bubble = NOP).
REQ-025 imem_addr and imem_req SHALL not change while a request is outstanding (request never retracted).
REQ-026 Throughput: one instruction per cycle with same-cycle imem_ack and freeze=0; latency pc_reg to valid output = 1 cycle after ack edge.
REQ-027 pc_reg addition wraps modulo 2^32; no alignment checks.

Reset
REQ-028 rst=0 at a rising edge: state=BOOT, pc_reg=RESET_PC, imem_addr=RESET_PC, imem_req=0, valid=0, PC=0, Instruction=0, skid cleared.
REQ-029 Reset mid-request abandons the outstanding access; memory side tolerates a dropped request after reset.

Structure
REQ-030 FSM state encodings and RESET_PC default live in the shared pipeline package.
REQ-031 Skid entry implemented as one sub-module if_skid_buffer (load, clear, 64-bit payload).

Verification
REQ-032 Reset, RESET_PC=0, same-cycle ack with rdata=32'hE3A0_0001 -> cycle after BOOT imem_addr=0; next edge valid=1, PC=4, Instruction=32'hE3A0_0001.
REQ-033 Continuous same-cycle acks, freeze=0 -> imem_addr 0,4,8,12 on consecutive cycles, PC 4,8,12,16, valid stays 1.
REQ-034 freeze=1 while slot valid and ack for addr 8 arrives -> WAIT_SLOT, imem_req=0, PC=8 held; freeze=0 -> PC=12 next edge, fetch resumes at 12.
REQ-035 branch_taken with branch_address=32'h100 while FETCH waiting (ack delayed 3 cycles) -> valid=0, PC=0, Instruction=0; stale ack discarded; next request imem_addr=32'h100.
REQ-036 branch_taken and freeze=1 in same cycle, slot and skid full -> both invalidated, next fetch at branch_address.
REQ-037 rst=0 asserted during DRAIN -> next edge all outputs at reset values, BOOT, then fetch at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package if_fetch_unit_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned PKT_W = 2 * XLEN;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] ST_BOOT      = 2'd0;
   localparam logic [1:0] ST_FETCH     = 2'd1;
   localparam logic [1:0] ST_WAIT_SLOT = 2'd2;
   localparam logic [1:0] ST_DRAIN     = 2'd3;

   // Fetched instruction: address-plus-4 and the instruction word.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched instruction that found the output slot busy.
module if_skid_buffer
   import if_fetch_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic       clear_i,
   input  fetch_pkt_t data_i,
   output logic       valid_o,
   output fetch_pkt_t data_o
);

   logic       valid_q;
   fetch_pkt_t data_q;

   // Clear wins over load so a redirect always empties the entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the instruction memory, buffers one early return
// in a skid entry, and presents {valid, PC, Instruction} to the IF/ID register.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_address,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] Instruction,
   output logic            valid
);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            req_q, req_d;
   logic            valid_q, valid_d;
   fetch_pkt_t      slot_q, slot_d;

   logic            skid_load_c;
   logic            skid_clear_c;
   logic            skid_valid_c;
   fetch_pkt_t      skid_data_c;
   fetch_pkt_t      fetched_c;
   logic [XLEN-1:0] pc_inc_c;
   logic            consume_c;
   logic            slot_free_c;

   assign consume_c   = valid_q & ~freeze;
   assign slot_free_c = ~valid_q | consume_c;
   assign pc_inc_c    = pc_q + XLEN'(4);
   assign fetched_c   = '{pc: pc_inc_c, instr: imem_rdata};

   if_skid_buffer u_skid (
      .clk     (clk),
      .rst_n   (rst),
      .load_i  (skid_load_c),
      .clear_i (skid_clear_c),
      .data_i  (fetched_c),
      .valid_o (skid_valid_c),
      .data_o  (skid_data_c)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         slot_q  <= slot_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      addr_d       = addr_q;
      valid_d      = valid_q;
      slot_d       = slot_q;
      skid_load_c  = 1'b0;
      skid_clear_c = 1'b0;

      // A consumed slot becomes a bubble unless refilled below; bubbles read as zero.
      if (consume_c) begin
         valid_d = 1'b0;
         slot_d  = '0;
      end

      if (branch_taken) begin
         pc_d         = branch_address;
         valid_d      = 1'b0;
         slot_d       = '0;
         skid_clear_c = 1'b1;
         case (state_q)
            ST_FETCH: begin
               if (imem_ack) begin
                  addr_d  = branch_address;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: state_d = ST_DRAIN;
            default: begin
               addr_d  = branch_address;
               state_d = ST_FETCH;
            end
         endcase
      end else begin
         case (state_q)
            ST_BOOT: begin
               addr_d  = pc_q;
               state_d = ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  pc_d = pc_inc_c;
                  if (slot_free_c) begin
                     valid_d = 1'b1;
                     slot_d  = fetched_c;
                     addr_d  = pc_inc_c;
                  end else begin
                     skid_load_c = 1'b1;
                     state_d     = ST_WAIT_SLOT;
                  end
               end
            end
            ST_WAIT_SLOT: begin
               if (consume_c) begin
                  valid_d      = skid_valid_c;
                  slot_d       = skid_data_c;
                  skid_clear_c = 1'b1;
                  addr_d       = pc_q;
                  state_d      = ST_FETCH;
               end
            end
            ST_DRAIN: begin
               // Returning data belongs to a flushed path and is dropped.
               if (imem_ack) begin
                  addr_d  = pc_q;
                  state_d = ST_FETCH;
               end
            end
            default: state_d = ST_BOOT;
         endcase
      end

      req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign valid       = valid_q;
   assign PC          = slot_q.pc;
   assign Instruction = slot_q.instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scenarios followed by randomized traffic checked against a program-order stream model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_address;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        valid;

   int unsigned checks = 0;
   int unsigned errors = 0;

   if_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .freeze         (freeze),
      .branch_taken   (branch_taken),
      .branch_address (branch_address),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .PC             (PC),
      .Instruction    (Instruction),
      .valid          (valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory image: every address holds a distinct word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a ^ 32'hE5A5_0000) + {a[15:0], a[31:16]};
   endfunction

   int unsigned exp_pc;
   int unsigned delivered;
   logic        prev_req;
   logic        prev_ack;
   logic [31:0] prev_addr;

   initial begin
      rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      step(); step();
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_pc",    PC, 32'h0);
      chk("rst_ins",   Instruction, 32'h0);

      rst = 1'b1; step();
      chk("boot_req",  32'(imem_req), 32'd1);
      chk("boot_addr", imem_addr, 32'h0);

      imem_ack = 1'b1; imem_rdata = 32'hE3A0_0001; step();
      chk("first_valid", 32'(valid), 32'd1);
      chk("first_pc",    PC, 32'h4);
      chk("first_ins",   Instruction, 32'hE3A0_0001);
      chk("first_addr",  imem_addr, 32'h4);
      for (int k = 1; k <= 3; k++) begin
         imem_rdata = mem_word(imem_addr); step();
         chk("thr_pc",    PC, 32'(4 + 4 * k));
         chk("thr_valid", 32'(valid), 32'd1);
         chk("thr_addr",  imem_addr, 32'(4 + 4 * k));
      end

      // Freeze with a full slot while the fetch of address 8 returns.
      imem_ack = 1'b0; rst = 1'b0; step();
      rst = 1'b1; step();
      for (int k = 0; k < 2; k++) begin
         imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); step();
      end
      chk("pre_ws_pc", PC, 32'h8);
      freeze = 1'b1; imem_rdata = mem_word(imem_addr); step();
      chk("ws_req",   32'(imem_req), 32'd0);
      chk("ws_pc",    PC, 32'h8);
      chk("ws_valid", 32'(valid), 32'd1);
      imem_ack = 1'b0; step();
      chk("ws_hold_pc",  PC, 32'h8);
      chk("ws_hold_req", 32'(imem_req), 32'd0);
      freeze = 1'b0; step();
      chk("rs_pc",   PC, 32'hC);
      chk("rs_ins",  Instruction, mem_word(32'h8));
      chk("rs_req",  32'(imem_req), 32'd1);
      chk("rs_addr", imem_addr, 32'hC);

      // Branch under freeze with slot and skid both occupied.
      freeze = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(32'hC); step();
      chk("full_req", 32'(imem_req), 32'd0);
      imem_ack = 1'b0; branch_taken = 1'b1; branch_address = 32'h200; step();
      chk("bf_valid", 32'(valid), 32'd0);
      chk("bf_pc",    PC, 32'h0);
      chk("bf_ins",   Instruction, 32'h0);
      chk("bf_req",   32'(imem_req), 32'd1);
      chk("bf_addr",  imem_addr, 32'h200);
      branch_taken = 1'b0; freeze = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(32'h200); step();
      chk("bf_next_pc",  PC, 32'h204);
      chk("bf_next_ins", Instruction, mem_word(32'h200));

      // Branch while a fetch is outstanding; the late return is stale.
      imem_ack = 1'b0; branch_taken = 1'b1; branch_address = 32'h100; step();
      chk("dr_valid", 32'(valid), 32'd0);
      chk("dr_pc",    PC, 32'h0);
      chk("dr_ins",   Instruction, 32'h0);
      chk("dr_req",   32'(imem_req), 32'd1);
      chk("dr_addr",  imem_addr, 32'h204);
      branch_taken = 1'b0; step(); step();
      chk("dr_hold_addr", imem_addr, 32'h204);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step();
      chk("dr_done_valid", 32'(valid), 32'd0);
      chk("dr_done_addr",  imem_addr, 32'h100);
      chk("dr_done_req",   32'(imem_req), 32'd1);
      imem_rdata = mem_word(32'h100); step();
      chk("dr_next_pc",  PC, 32'h104);
      chk("dr_next_ins", Instruction, mem_word(32'h100));

      // Reset while draining.
      imem_ack = 1'b0; branch_taken = 1'b1; branch_address = 32'h300; step();
      branch_taken = 1'b0; rst = 1'b0; step();
      chk("rd_req",   32'(imem_req), 32'd0);
      chk("rd_addr",  imem_addr, 32'h0);
      chk("rd_valid", 32'(valid), 32'd0);
      chk("rd_pc",    PC, 32'h0);
      chk("rd_ins",   Instruction, 32'h0);
      rst = 1'b1; step();
      chk("rd_boot_req",  32'(imem_req), 32'd1);
      chk("rd_boot_addr", imem_addr, 32'h0);

      // Randomized traffic: the delivered stream must follow program order from each redirect.
      rst = 1'b0; step();
      rst = 1'b1;
      exp_pc = 0;
      delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         freeze         = ($urandom_range(0, 99) < 30);
         branch_taken   = ($urandom_range(0, 99) < 6);
         branch_address = 32'($urandom_range(0, 4095)) << 2;
         imem_ack       = imem_req && ($urandom_range(0, 99) < 60);
         imem_rdata     = imem_ack ? mem_word(imem_addr) : $urandom();
         if (!valid) begin
            chk("bubble_pc",  PC, 32'h0);
            chk("bubble_ins", Instruction, 32'h0);
         end else if (!freeze) begin
            chk("stream_pc",  PC, 32'(exp_pc + 4));
            chk("stream_ins", Instruction, mem_word(32'(exp_pc)));
            exp_pc = exp_pc + 4;
            delivered++;
         end
         if (branch_taken) exp_pc = branch_address;
         prev_req  = imem_req;
         prev_ack  = imem_ack;
         prev_addr = imem_addr;
         step();
         if (prev_req && !prev_ack) begin
            chk("req_hold",  32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, prev_addr);
         end
      end
      chk("progress", 32'(delivered > 200), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
